// File: rtl/case_8_mul_pkg.sv
// Shared definitions for the pipelined handshake multiplier.
//   prod_width : width of the internal product, one bit wider than a*b so the
//                rounding add can never carry out.
//   lim_max / lim_min : representable range of the result for a given width
//                and signedness, used for overflow detection and saturation.
//   CASE_8_MUL_CHECK_STAGES : elaboration-time guard on the pipeline depth.

`define CASE_8_MUL_CHECK_STAGES(n, tag) \
  if ((n) < 1 || (n) > 8) begin : g_bad_num_stage \
    $error("case_8_mul_pipe_hs %0d: NUM_STAGE=%0d outside 1..8", tag, n); \
  end

package case_8_mul_pkg;

  function automatic int prod_width(input int a, input int b);
    return a + b + 1;
  endfunction

  function automatic logic signed [63:0] lim_max(input int w, input bit sgn);
    return sgn ? (64'sd1 <<< (w - 1)) - 64'sd1 : (64'sd1 <<< w) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] lim_min(input int w, input bit sgn);
    return sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/case_8_mul_post.sv
// Combinational post-processing of the full product.
//   p_i    : full product, two's complement, W bits
//   dout_o : rounded/shifted result, wrapped or saturated to DOUT_W bits
//   ovf_o  : shifted result lies outside the DOUT_W range
module case_8_mul_post
  import case_8_mul_pkg::*;
#(
  parameter int W       = 18,
  parameter int DOUT_W  = 16,
  parameter int SHIFT   = 0,
  parameter int ROUND   = 0,
  parameter int SAT     = 0,
  parameter int OSIGNED = 1
) (
  input  logic [W-1:0]      p_i,
  output logic [DOUT_W-1:0] dout_o,
  output logic              ovf_o
);

  // One extra bit so an unsigned DOUT_W == W range still fits as a signed limit.
  localparam int CW = W + 1;
  localparam logic [W-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? (W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [CW-1:0] LIM_HI = CW'(lim_max(DOUT_W, OSIGNED != 0));
  localparam logic signed [CW-1:0] LIM_LO = CW'(lim_min(DOUT_W, OSIGNED != 0));

  logic [W-1:0]         sum;
  logic signed [W-1:0]  r;
  logic signed [CW-1:0] r_ext;
  logic                 hi, lo;

  always_comb begin
    sum   = p_i + RND;
    r     = $signed(sum) >>> SHIFT;
    r_ext = CW'(r);
    hi    = r_ext > LIM_HI;
    lo    = r_ext < LIM_LO;
    ovf_o = hi | lo;
    if (SAT != 0 && hi) begin
      dout_o = LIM_HI[DOUT_W-1:0];
    end else if (SAT != 0 && lo) begin
      dout_o = LIM_LO[DOUT_W-1:0];
    end else begin
      dout_o = r[DOUT_W-1:0];
    end
  end

endmodule

// File: rtl/case_8_mul_pipe_hs.sv
// Pipelined fixed-point multiplier with valid/ready on both sides.
//   ap_clk, ap_rst_n      : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake, din0/din1 operands
//   out_valid/out_ready   : result handshake, dout result, ovf per-result flag
//   ovf_sticky / ovf_clr  : sticky overflow and its clear (set wins)
// Stage 0 holds the full product; the final stage holds the post-processed
// result. Stages collapse bubbles: a stage loads when empty or draining.
module case_8_mul_pipe_hs
  import case_8_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 9,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 16,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  localparam int W       = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int PN      = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam int OSIGNED = (SIGNED0 != 0 || SIGNED1 != 0) ? 1 : 0;

  `CASE_8_MUL_CHECK_STAGES(NUM_STAGE, ID)

  logic [NUM_STAGE-1:0]  vld, ld;
  logic [W-1:0]          a_ext, b_ext, prod, post_in;
  logic [W-1:0]          p_arr [PN];
  logic [dout_WIDTH-1:0] post_dout, dout_q;
  logic                  post_ovf, ovf_q, sticky_q, sticky_d;

  always_comb begin
    a_ext = (SIGNED0 != 0) ? W'($signed(din0)) : W'(din0);
    b_ext = (SIGNED1 != 0) ? W'($signed(din1)) : W'(din1);
    prod  = a_ext * b_ext;
  end

  // A stage may load when it is empty or its content is taken downstream;
  // the chain runs from out_ready back to in_ready.
  always_comb begin : p_ready
    logic take;
    take = out_ready;
    ld   = '0;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      ld[k] = ~vld[k] | take;
      take  = ld[k];
    end
  end

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    logic v_q, v_d, src_v;

    if (k == 0) begin : g_src_in
      assign src_v = in_valid;
    end else begin : g_src_chain
      assign src_v = vld[k-1];
    end

    assign v_d    = ld[k] ? src_v : v_q;
    assign vld[k] = v_q;

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) v_q <= 1'b0;
      else           v_q <= v_d;
    end

    if (k == NUM_STAGE - 1) begin : g_last
      always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
          dout_q <= '0;
          ovf_q  <= 1'b0;
        end else if (ld[k] && src_v) begin
          dout_q <= post_dout;
          ovf_q  <= post_ovf;
        end
      end
    end else begin : g_mid
      logic [W-1:0] p_q, p_d;
      if (k == 0) begin : g_mul
        assign p_d = prod;
      end else begin : g_fwd
        assign p_d = p_arr[k-1];
      end
      always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)          p_q <= '0;
        else if (ld[k] && src_v) p_q <= p_d;
      end
      assign p_arr[k] = p_q;
    end
  end

  if (NUM_STAGE == 1) begin : g_post_direct
    assign post_in = prod;
  end else begin : g_post_piped
    assign post_in = p_arr[NUM_STAGE-2];
  end

  case_8_mul_post #(
    .W       (W),
    .DOUT_W  (dout_WIDTH),
    .SHIFT   (SHIFT),
    .ROUND   (ROUND),
    .SAT     (SAT),
    .OSIGNED (OSIGNED)
  ) u_post (
    .p_i    (post_in),
    .dout_o (post_dout),
    .ovf_o  (post_ovf)
  );

  // Set by a transferred overflowing result; a simultaneous clear loses.
  assign sticky_d = (vld[NUM_STAGE-1] & out_ready & ovf_q) ? 1'b1 :
                    (ovf_clr ? 1'b0 : sticky_q);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) sticky_q <= 1'b0;
    else           sticky_q <= sticky_d;
  end

  assign in_ready   = ld[0];
  assign out_valid  = vld[NUM_STAGE-1];
  assign dout       = dout_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule
